// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: groups the producer write port and the UART transmit handshake of
// uart_tx_buffer.
//   slave  : the buffer side (takes writes and UART status, drives FIFO status and send_*).
//   master : the environment side (producer plus UART transmitter).
// Signals: wr_en, wr_data[7:0], full, empty, count[AW:0], send_start, send_data[7:0],
//          send_busy, send_finish.
interface uart_tx_buffer_if #(
    parameter int unsigned AW = 4
) ();
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          send_start;
    logic [7:0]    send_data;
    logic          send_busy;
    logic          send_finish;

    modport slave (
        input  wr_en, wr_data, send_busy, send_finish,
        output full, empty, count, send_start, send_data
    );

    modport master (
        output wr_en, wr_data, send_busy, send_finish,
        input  full, empty, count, send_start, send_data
    );
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: 2**AW x 8 byte FIFO placed in front of a UART transmitter. Bytes are
// accepted at full clock rate and handed to the UART one at a time (send_start pulse with
// send_data), pacing on send_busy / send_finish.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   overflow   : sticky write-when-full flag (only with UART_TX_BUFFER_OVF_EN defined)
//   bus        : uart_tx_buffer_if.slave (producer write port, FIFO status, UART handshake)
// Build option: `define UART_TX_BUFFER_OVF_EN to add the overflow flag and port.
module uart_tx_buffer #(
    parameter int unsigned AW = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef UART_TX_BUFFER_OVF_EN
    output logic            overflow,
`endif
    uart_tx_buffer_if.slave bus
);
    localparam int unsigned   Depth     = 2 ** AW;
    localparam logic [AW:0]   CountFull = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] PtrOne    = AW'(1);
    localparam logic [AW:0]   CountOne  = (AW + 1)'(1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [Depth];
    logic [7:0]    mem_d [Depth];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;
    logic          send_start_q, send_start_d;
    logic [7:0]    send_data_q, send_data_d;
    logic          full, empty, push, pop;

    // Status comes from the registered count only, so a pop never frees room for a
    // write in the same cycle.
    assign full  = (count_q == CountFull);
    assign empty = (count_q == '0);
    assign push  = bus.wr_en && !full;
    assign pop   = (state_q == StIdle) && !empty && !bus.send_busy;

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        if (push) begin
            mem_d[wp_q] = bus.wr_data;
            wp_d        = wp_q + PtrOne;
        end
    end

    always_comb begin
        state_d      = state_q;
        rp_d         = rp_q;
        send_start_d = 1'b0;
        send_data_d  = send_data_q;
        unique case (state_q)
            StIdle: begin
                // A send_finish seen here belongs to a transfer from before a reset.
                if (pop) begin
                    send_data_d  = mem_q[rp_q];
                    send_start_d = 1'b1;
                    rp_d         = rp_q + PtrOne;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (bus.send_finish) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            send_start_q <= 1'b0;
            send_data_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            send_start_q <= send_start_d;
            send_data_q  <= send_data_d;
        end
    end

`ifdef UART_TX_BUFFER_OVF_EN
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | (bus.wr_en & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`endif

    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.count      = count_q;
    assign bus.send_start = send_start_q;
    assign bus.send_data  = send_data_q;
endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte FIFO that sits directly upstream of the `uart` transmit port. It accepts bytes from a producer at full clock rate and feeds them one at a time to the UART via `send_start`/`send_data`, pacing on `send_busy`/`send_finish`. It decouples bursty producers, such as a command responder or a test pattern generator, from the slow serial line.

## Interface
- `AW`, default 4: address width; buffer depth is `DEPTH = 2**AW` (16 by default).
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `wr_en`  in  1  producer write strobe.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  high when count == DEPTH.
- `empty`  out  1  high when count == 0.
- `count`  out  AW+1  bytes currently stored, range 0..DEPTH.
- `send_start`  out  1  one-cycle pulse to the UART; `send_data` is valid in the same cycle.
- `send_data`  out  8  byte being transmitted; held stable until `send_finish`.
- `send_busy`  in  1  UART transmitter busy.
- `send_finish`  in  1  UART one-cycle pulse at end of the stop bit.
- `overflow`  out  1  sticky write-when-full flag; present only with `UART_TX_BUFFER_OVF_EN`.

## Operation
- Storage: DEPTH×8 register array, write pointer `wp` and read pointer `rp`, each AW bits, wrapping modulo DEPTH. `count` is maintained separately.
- Write: when `wr_en && !full`, store `wr_data` at `wp` and increment `wp`. When `wr_en && full`, the byte is dropped and no state changes.
- `full` and `empty` derive from the registered `count`. A write in the same cycle as a pop when full is still rejected; there is no pass-through.
- Simultaneous accepted write and pop: `count` is unchanged and both pointers advance.
- FSM states:
  - IDLE: if `!empty && !send_busy`:
    - `send_data <= mem[rp]`, `rp++`, `send_start <= 1`.
    - Go to WAIT.
  - WAIT: `send_start <= 0` after one cycle. Stay in WAIT until `send_finish` = 1, then go to IDLE.
- `send_finish` received in IDLE is ignored (e.g. a transfer that was in flight across a reset).
- `send_busy` high in IDLE stalls the pop; the byte stays in the FIFO.
- Reset:
  - State: IDLE; `wp`, `rp` and `count` are 0.
  - Outputs: `send_start` 0, `send_data` 8'h00, `full` 0, `empty` 1, `count` 0, `overflow` 0.
  - Mid-operation reset discards all buffered bytes. It does not abort a UART transfer already started.

## Timing
- Write accepted at edge N: `count` and `empty` update after edge N.
- From an empty FIFO with `send_busy` low, `send_start` is high in the cycle after edge N+1. This is 2 cycles of write-to-start latency.
- `send_start` is high for exactly one cycle per popped byte.
- `send_data` changes only on the edge that raises `send_start`.
- Back-to-back bytes: the next `send_start` comes 2 cycles after the `send_finish` cycle (WAIT→IDLE, then IDLE pop). The serial gap per byte is therefore fixed and independent of FIFO level.
- Throughput ceiling: one byte per UART frame + 2 clocks.

## Configuration
- `UART_TX_BUFFER_OVF_EN` defined:
  - Adds the `overflow` port.
  - `overflow` is set on the edge where `wr_en && full`, stays high until `rst`, and is never cleared otherwise.
- Not defined:
  - No `overflow` port and no flag register.
  - Writes when full are silently dropped; all other behaviour is identical.

## Test plan
- Reset values: hold `rst` high → `empty`=1, `full`=0, `count`=0, `send_start`=0, `send_data`=8'h00. Assert `rst` mid-WAIT → same values on the next cycle.
- Single byte: write 8'hA5 into an empty FIFO with `send_busy`=0 → `send_start` pulses one cycle, 2 cycles later, with `send_data`=8'hA5. `count` returns to 0. No second pulse before `send_finish`.
- Order and wrap: write 8'h00..8'h13 (20 bytes, DEPTH 16) while the UART model takes 50 cycles per byte → bytes emitted in order 8'h00..8'h13. Pointers wrap with no loss once the writes are paced to avoid full.
- Full and drop: with `send_busy` held 1, write 17 bytes 8'h10..8'h20 → `full`=1 and `count`=16 after the 16th write. 8'h20 is not stored; after release, exactly 8'h10..8'h1F are sent. With `UART_TX_BUFFER_OVF_EN`, `overflow`=1 from the 17th write edge onward.
- Simultaneous write and pop: with `count`=3, assert `wr_en` on the cycle the IDLE pop occurs → `count` stays 3 and the new byte is sent last.
- Stall: `count`=2, `send_busy`=1 in IDLE for 10 cycles → no `send_start`. `send_start` appears on the cycle after `send_busy` falls plus one edge.
